// File: rtl/lock_pkg.sv
// Shared types and helpers for the keypad lock controller.
// Contents: FSM state enum (encoding is visible on state_o), special key codes,
// digit classification and entry-buffer digit insertion.
package lock_pkg;

    typedef enum logic [2:0] {
        LOCKED   = 3'd0,
        ENTRY    = 3'd1,
        CHECK    = 3'd2,
        UNLOCKED = 3'd3,
        PROG     = 3'd4,
        FAIL     = 3'd5,
        LOCKOUT  = 3'd6
    } lock_state_t;

    localparam logic [3:0] KEY_PROG  = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hE;

    // Keys 0..9 are digits; everything above is a command or ignored.
    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

    // Place a digit at position cnt, first digit in the top nibble.
    function automatic logic [15:0] put_digit(input logic [15:0] entry,
                                              input logic [2:0]  cnt,
                                              input logic [3:0]  key);
        logic [15:0] r;
        r = entry;
        case (cnt)
            3'd0:    r[15:12] = key;
            3'd1:    r[11:8]  = key;
            3'd2:    r[7:4]   = key;
            3'd3:    r[3:0]   = key;
            default: r = entry;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ms_timer.sv
// Millisecond timeout timer: a cycle prescaler feeding a saturating ms counter.
// Ports: clk, rst (async, active-high); restart clears the count; load_ms is the
// timeout length in ms (0 = never expire); expire is a registered 1-cycle pulse
// whose effect lands exactly load_ms*(CLK_FREQ/1000) cycles after restart.
module ms_timer #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned MAX_MS   = 10_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         restart,
    input  logic [$clog2(MAX_MS+1)-1:0]  load_ms,
    output logic                         expire
);

    localparam int unsigned TICK  = CLK_FREQ / 1000;
    localparam int unsigned PRE_W = $clog2(TICK);
    localparam int unsigned MS_W  = $clog2(MAX_MS + 1);

    logic [PRE_W-1:0] pre;
    logic [MS_W-1:0]  ms;

    // expire is raised one cycle early so the registered pulse is seen in the
    // last cycle of the interval and the consumer acts on its final edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre    <= '0;
            ms     <= '0;
            expire <= 1'b0;
        end else if (restart) begin
            pre    <= '0;
            ms     <= '0;
            expire <= 1'b0;
        end else begin
            if (pre == PRE_W'(TICK - 1)) begin
                pre <= '0;
                if (ms != MS_W'(MAX_MS))
                    ms <= ms + MS_W'(1);
            end else begin
                pre <= pre + PRE_W'(1);
            end
            expire <= (load_ms != '0) && (ms == load_ms - MS_W'(1)) &&
                      (pre == PRE_W'(TICK - 2));
        end
    end

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad lock sequencer: assembles a 4-digit entry, checks it against the
// stored code, handles unlock/relock, error, lockout and code reprogramming.
// Ports: clk, rst (async, active-high); key_valid/key_value debounced key pulse;
// unlocked/err/alarm/prog_mode status flags; entry_buf/entry_cnt entry digits
// for the display; fail_cnt consecutive failures; state_o raw FSM state.
module keypad_lock_ctrl
    import lock_pkg::*;
#(
    parameter int unsigned CLK_FREQ         = 50_000_000,
    parameter logic [15:0] DEFAULT_CODE     = 16'h1234,
    parameter int unsigned MAX_FAILS        = 3,
    parameter int unsigned UNLOCK_MS        = 5000,
    parameter int unsigned ENTRY_TIMEOUT_MS = 5000,
    parameter int unsigned FAIL_MS          = 1000,
    parameter int unsigned LOCKOUT_MS       = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_value,
    output logic        unlocked,
    output logic        err,
    output logic        alarm,
    output logic        prog_mode,
    output logic [15:0] entry_buf,
    output logic [2:0]  entry_cnt,
    output logic [1:0]  fail_cnt,
    output logic [2:0]  state_o
);

    localparam int unsigned MAX_AB = (UNLOCK_MS > ENTRY_TIMEOUT_MS) ? UNLOCK_MS : ENTRY_TIMEOUT_MS;
    localparam int unsigned MAX_CD = (FAIL_MS > LOCKOUT_MS) ? FAIL_MS : LOCKOUT_MS;
    localparam int unsigned MAX_MS = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned MS_W   = $clog2(MAX_MS + 1);

    lock_state_t       state, state_nxt;
    logic [15:0]       code_reg, code_nxt, buf_nxt;
    logic [2:0]        cnt_nxt;
    logic [1:0]        fail_nxt, fail_inc;
    logic              digit_ok, accepted, timer_restart, timer_expire;
    logic [MS_W-1:0]   load_ms;

    assign state_o  = state;
    assign fail_inc = fail_cnt + 2'd1;
    // A digit is only taken while the buffer still has room.
    assign digit_ok = key_valid && is_digit(key_value) && (entry_cnt != 3'd4);

    ms_timer #(
        .CLK_FREQ (CLK_FREQ),
        .MAX_MS   (MAX_MS)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (timer_restart),
        .load_ms (load_ms),
        .expire  (timer_expire)
    );

    // Next-state, register updates and timer control.
    always_comb begin
        state_nxt = state;
        code_nxt  = code_reg;
        buf_nxt   = entry_buf;
        cnt_nxt   = entry_cnt;
        fail_nxt  = fail_cnt;
        accepted  = 1'b0;
        load_ms   = '0;

        case (state)
            LOCKED: begin
                if (digit_ok) begin
                    buf_nxt   = put_digit(entry_buf, entry_cnt, key_value);
                    cnt_nxt   = entry_cnt + 3'd1;
                    state_nxt = ENTRY;
                end
            end
            ENTRY: begin
                load_ms = MS_W'(ENTRY_TIMEOUT_MS);
                if (timer_expire) begin
                    buf_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = LOCKED;
                end else if (digit_ok) begin
                    buf_nxt  = put_digit(entry_buf, entry_cnt, key_value);
                    cnt_nxt  = entry_cnt + 3'd1;
                    accepted = 1'b1;
                end else if (key_valid && key_value == KEY_CLEAR) begin
                    buf_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = LOCKED;
                end else if (key_valid && key_value == KEY_ENTER) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                buf_nxt = '0;
                cnt_nxt = '0;
                if (entry_cnt == 3'd4 && entry_buf == code_reg) begin
                    fail_nxt  = '0;
                    state_nxt = UNLOCKED;
                end else begin
                    fail_nxt  = fail_inc;
                    state_nxt = (fail_inc == 2'(MAX_FAILS)) ? LOCKOUT : FAIL;
                end
            end
            UNLOCKED: begin
                load_ms = MS_W'(UNLOCK_MS);
                if (timer_expire) begin
                    state_nxt = LOCKED;
                end else if (key_valid && key_value == KEY_PROG) begin
                    buf_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = PROG;
                end else if (key_valid && key_value == KEY_CLEAR) begin
                    state_nxt = LOCKED;
                end
            end
            PROG: begin
                load_ms = MS_W'(ENTRY_TIMEOUT_MS);
                if (timer_expire) begin
                    buf_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = LOCKED;
                end else if (digit_ok) begin
                    buf_nxt  = put_digit(entry_buf, entry_cnt, key_value);
                    cnt_nxt  = entry_cnt + 3'd1;
                    accepted = 1'b1;
                end else if (key_valid && key_value == KEY_ENTER && entry_cnt == 3'd4) begin
                    code_nxt  = entry_buf;
                    buf_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = UNLOCKED;
                end else if (key_valid && key_value == KEY_CLEAR) begin
                    buf_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = UNLOCKED;
                end
            end
            FAIL: begin
                load_ms = MS_W'(FAIL_MS);
                if (timer_expire)
                    state_nxt = LOCKED;
            end
            LOCKOUT: begin
                load_ms = MS_W'(LOCKOUT_MS);
                if (timer_expire) begin
                    fail_nxt  = '0;
                    state_nxt = LOCKED;
                end
            end
            default: begin
                buf_nxt   = '0;
                cnt_nxt   = '0;
                state_nxt = LOCKED;
            end
        endcase

        timer_restart = (state_nxt != state) || accepted;
    end

    // State and datapath registers; flags decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOCKED;
            code_reg  <= DEFAULT_CODE;
            entry_buf <= '0;
            entry_cnt <= '0;
            fail_cnt  <= '0;
            unlocked  <= 1'b0;
            err       <= 1'b0;
            alarm     <= 1'b0;
            prog_mode <= 1'b0;
        end else begin
            state     <= state_nxt;
            code_reg  <= code_nxt;
            entry_buf <= buf_nxt;
            entry_cnt <= cnt_nxt;
            fail_cnt  <= fail_nxt;
            unlocked  <= (state_nxt == UNLOCKED) || (state_nxt == PROG);
            err       <= (state_nxt == FAIL);
            alarm     <= (state_nxt == LOCKOUT);
            prog_mode <= (state_nxt == PROG);
        end
    end

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Testbench for keypad_lock_ctrl: directed scenarios followed by random key
// traffic, every cycle compared against a cycle-counting behavioural model.
module tb_keypad_lock_ctrl;

    localparam int TICK = 10;  // CLK_FREQ 10_000 -> 10 cycles per ms

    localparam int M_LOCKED = 0, M_ENTRY = 1, M_CHECK = 2, M_UNLOCKED = 3,
                   M_PROG = 4, M_FAIL = 5, M_LOCKOUT = 6;

    logic        clk;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_value;
    logic        unlocked, err, alarm, prog_mode;
    logic [15:0] entry_buf;
    logic [2:0]  entry_cnt;
    logic [1:0]  fail_cnt;
    logic [2:0]  state_o;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_mode;
    logic [15:0] m_buf;
    int          m_cnt;
    int          m_fails;
    logic [15:0] m_code;
    int          m_elapsed;

    keypad_lock_ctrl #(
        .CLK_FREQ         (10_000),
        .DEFAULT_CODE     (16'h1234),
        .MAX_FAILS        (3),
        .UNLOCK_MS        (5),
        .ENTRY_TIMEOUT_MS (4),
        .FAIL_MS          (2),
        .LOCKOUT_MS       (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_value (key_value),
        .unlocked  (unlocked),
        .err       (err),
        .alarm     (alarm),
        .prog_mode (prog_mode),
        .entry_buf (entry_buf),
        .entry_cnt (entry_cnt),
        .fail_cnt  (fail_cnt),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int limit_ms(input int mode);
        case (mode)
            M_ENTRY, M_PROG: return 4;
            M_UNLOCKED:      return 5;
            M_FAIL:          return 2;
            M_LOCKOUT:       return 6;
            default:         return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_LOCKED; m_buf = 16'h0; m_cnt = 0; m_fails = 0;
        m_code = 16'h1234; m_elapsed = 0;
    endtask

    task automatic model_put(input logic [3:0] k);
        m_buf = m_buf | (16'(k) << (12 - 4 * m_cnt));
        m_cnt++;
    endtask

    task automatic model_clear();
        m_buf = 16'h0; m_cnt = 0;
    endtask

    // One clock edge of the lock's behaviour, inputs as seen before the edge.
    task automatic model_step(input logic v, input logic [3:0] k);
        int prev, lim;
        bit restart, expired, digit;
        prev    = m_mode;
        restart = 0;
        digit   = v && (k <= 4'd9);
        lim     = limit_ms(m_mode);
        expired = (lim > 0) && (m_elapsed == lim * TICK - 1);
        case (m_mode)
            M_LOCKED: if (digit) begin model_put(k); m_mode = M_ENTRY; end
            M_ENTRY: begin
                if (expired) begin model_clear(); m_mode = M_LOCKED; end
                else if (digit && m_cnt < 4) begin model_put(k); restart = 1; end
                else if (v && k == 4'hC) begin model_clear(); m_mode = M_LOCKED; end
                else if (v && k == 4'hE) m_mode = M_CHECK;
            end
            M_CHECK: begin
                if (m_cnt == 4 && m_buf == m_code) begin
                    m_fails = 0; m_mode = M_UNLOCKED;
                end else begin
                    m_fails++;
                    m_mode = (m_fails == 3) ? M_LOCKOUT : M_FAIL;
                end
                model_clear();
            end
            M_UNLOCKED: begin
                if (expired) m_mode = M_LOCKED;
                else if (v && k == 4'hA) begin model_clear(); m_mode = M_PROG; end
                else if (v && k == 4'hC) m_mode = M_LOCKED;
            end
            M_PROG: begin
                if (expired) begin model_clear(); m_mode = M_LOCKED; end
                else if (digit && m_cnt < 4) begin model_put(k); restart = 1; end
                else if (v && k == 4'hE && m_cnt == 4) begin
                    m_code = m_buf; model_clear(); m_mode = M_UNLOCKED;
                end
                else if (v && k == 4'hC) begin model_clear(); m_mode = M_UNLOCKED; end
            end
            M_FAIL:    if (expired) m_mode = M_LOCKED;
            M_LOCKOUT: if (expired) begin m_fails = 0; m_mode = M_LOCKED; end
            default:   m_mode = M_LOCKED;
        endcase
        m_elapsed = (m_mode != prev || restart) ? 0 : m_elapsed + 1;
    endtask

    task automatic compare_all();
        chk("unlocked",  16'(unlocked),  16'(m_mode == M_UNLOCKED || m_mode == M_PROG));
        chk("err",       16'(err),       16'(m_mode == M_FAIL));
        chk("alarm",     16'(alarm),     16'(m_mode == M_LOCKOUT));
        chk("prog_mode", 16'(prog_mode), 16'(m_mode == M_PROG));
        chk("entry_buf", entry_buf,      m_buf);
        chk("entry_cnt", 16'(entry_cnt), 16'(m_cnt));
        chk("fail_cnt",  16'(fail_cnt),  16'(m_fails));
        chk("state_o",   16'(state_o),   16'(m_mode));
    endtask

    task automatic cycle(input logic v, input logic [3:0] k);
        key_valid = v;
        key_value = k;
        @(posedge clk);
        model_step(v, k);
        #1;
        key_valid = 1'b0;
        key_value = 4'h0;
        compare_all();
    endtask

    task automatic press(input logic [3:0] k);
        cycle(1'b1, k);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 4'h0);
    endtask

    task automatic enter_code(input logic [15:0] c);
        logic [15:0] cc;
        cc = c;
        for (int j = 0; j < 4; j++) press(cc[15 - 4 * j -: 4]);
        press(4'hE);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        key_valid = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        key_valid = 1'b0;
        key_value = 4'h0;
        model_reset();
        #1;
        chk("reset_state",    16'(state_o),   16'd0);
        chk("reset_buf",      entry_buf,      16'h0);
        chk("reset_unlocked", 16'(unlocked),  16'd0);
        do_reset();

        // Correct code, then auto-relock after 50 cycles
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        chk("ok_buf", entry_buf, 16'h1234);
        chk("ok_cnt", 16'(entry_cnt), 16'd4);
        press(4'hE);
        idle(1);
        chk("ok_unlocked", 16'(unlocked), 16'd1);
        chk("ok_fail0", 16'(fail_cnt), 16'd0);
        idle(49);
        chk("ok_still_open", 16'(unlocked), 16'd1);
        idle(1);
        chk("ok_relocked", 16'(unlocked), 16'd0);

        // Three wrong attempts -> two error windows then lockout
        for (int a = 1; a <= 3; a++) begin
            enter_code(16'h1235);
            idle(1);
            if (a < 3) begin
                chk("wrong_err", 16'(err), 16'd1);
                chk("wrong_fails", 16'(fail_cnt), 16'(a));
                idle(19);
                chk("wrong_err_hold", 16'(err), 16'd1);
                idle(1);
                chk("wrong_err_end", 16'(err), 16'd0);
            end else begin
                chk("lockout_alarm", 16'(alarm), 16'd1);
                press(4'h1); press(4'hE); press(4'hC); press(4'hA);
                idle(55);
                chk("lockout_hold", 16'(alarm), 16'd1);
                chk("lockout_nobuf", 16'(entry_cnt), 16'd0);
                idle(1);
                chk("lockout_end", 16'(alarm), 16'd0);
                chk("lockout_fail0", 16'(fail_cnt), 16'd0);
            end
        end

        // Short entry fails; a fifth digit is dropped
        press(4'h1); press(4'h2); press(4'hE);
        idle(1);
        chk("short_err", 16'(err), 16'd1);
        chk("short_fails", 16'(fail_cnt), 16'd1);
        idle(20);
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h9);
        chk("fifth_buf", entry_buf, 16'h1234);
        press(4'hC);

        // Reprogram to 9876, verify, then reset restores 1234
        enter_code(16'h1234);
        idle(1);
        press(4'hA);
        chk("prog_mode", 16'(prog_mode), 16'd1);
        enter_code(16'h9876);
        chk("prog_open", 16'(unlocked), 16'd1);
        chk("prog_exit", 16'(prog_mode), 16'd0);
        press(4'hC);
        chk("prog_relock", 16'(unlocked), 16'd0);
        enter_code(16'h9876);
        idle(1);
        chk("new_code_ok", 16'(unlocked), 16'd1);
        press(4'hC);
        enter_code(16'h1234);
        idle(1);
        chk("old_code_bad", 16'(err), 16'd1);
        idle(20);
        do_reset();
        enter_code(16'h1234);
        idle(1);
        chk("reset_code_ok", 16'(unlocked), 16'd1);
        press(4'hC);

        // Entry timeout, and key dropped on the expiry cycle
        press(4'h1);
        idle(40);
        chk("timeout_cnt", 16'(entry_cnt), 16'd0);
        chk("timeout_state", 16'(state_o), 16'd0);
        press(4'h1);
        idle(39);
        press(4'h5);
        chk("expiry_drop_cnt", 16'(entry_cnt), 16'd0);
        chk("expiry_drop_buf", entry_buf, 16'h0);

        // Ignored keys
        press(4'hB); press(4'hD); press(4'hF); press(4'hE); press(4'hC); press(4'hA);
        chk("ign_locked", 16'(state_o), 16'd0);
        press(4'h7); press(4'hB); press(4'hD); press(4'hF); press(4'hA);
        chk("ign_entry_buf", entry_buf, 16'h7000);
        chk("ign_entry_cnt", 16'(entry_cnt), 16'd1);
        press(4'hC);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            if ($urandom_range(0, 7) == 0) enter_code(m_code);
            else if ($urandom_range(0, 1) == 1) press(4'($urandom_range(0, 15)));
            else idle(int'($urandom_range(1, 8)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/keypad_lock_ctrl.md
Name: keypad_lock_ctrl

Overview:
Sequencing controller for the keypad digital lock. It consumes the debounced single-cycle key pulse and the decoded key value, then assembles a 4-digit entry and compares it with a stored code. It drives the unlock, error and lockout indications and supports re-programming the code while unlocked. It sits between the keypad decode/debounce chain and the SSD display mux, and its entry buffer feeds the four display digits.

Parameters:
CLK_FREQ, 50_000_000, clock frequency in Hz; ms tick = CLK_FREQ/1000 cycles.
DEFAULT_CODE, 16'h1234, code loaded at reset; first digit in [15:12].
MAX_FAILS, 3, consecutive failed attempts that trigger lockout; legal range 1..3.
UNLOCK_MS, 5000, unlocked hold time before auto-relock.
ENTRY_TIMEOUT_MS, 5000, idle time that aborts a partial entry.
FAIL_MS, 1000, error indication time.
LOCKOUT_MS, 10000, lockout duration.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
key_valid  in  1  single-cycle pulse, one per accepted key press
key_value  in  4  decoded key, sampled when key_valid=1
unlocked  out  1  lock open
err  out  1  wrong-code indication
alarm  out  1  lockout active
prog_mode  out  1  code-programming in progress
entry_buf  out  16  entered digits; first digit in [15:12], unused nibbles 0
entry_cnt  out  3  digits entered, 0..4
fail_cnt  out  2  consecutive failures
state_o  out  3  current FSM state encoding, for debug/RGB

Behaviour:
- Reset: state LOCKED, code_reg=DEFAULT_CODE, entry_buf=0, entry_cnt=0, fail_cnt=0, timer cleared, all flag outputs 0.
- Key classes: 0x0-0x9 are digits; 0xA=PROG; 0xC=CLEAR; 0xE=ENTER; 0xB, 0xD and 0xF are ignored in every state.
- All outputs are registered and decoded from the state/registers: unlocked=1 in UNLOCKED and PROG; err=1 in FAIL; alarm=1 in LOCKOUT; prog_mode=1 in PROG.
- Digit accept: entry_buf nibble [15-4*entry_cnt -: 4] <= key; entry_cnt++. Digits arriving when entry_cnt=4 are ignored and do not restart the timer.
- Timer: ms prescaler plus ms counter. It restarts on every state transition and on every accepted digit/CLEAR in ENTRY/PROG. An N ms timeout fires exactly N*(CLK_FREQ/1000) cycles after restart.
- Timer expiry and key_valid in the same cycle: expiry has priority and the key is dropped.
- States:
  - LOCKED: digit -> accept, go ENTRY. ENTER, CLEAR and PROG are ignored.
  - ENTRY:
    - digit -> accept.
    - CLEAR -> clear buffer and count, go LOCKED; no fail is counted.
    - ENTER -> go CHECK, regardless of entry_cnt.
    - ENTRY_TIMEOUT_MS expiry -> clear buffer, go LOCKED; no fail is counted.
  - CHECK (1 cycle, keys ignored):
    - Match requires entry_cnt==4 and entry_buf==code_reg. On match -> UNLOCKED, fail_cnt=0.
    - Otherwise fail_cnt++. If the new value equals MAX_FAILS -> LOCKOUT, else -> FAIL.
    - Buffer is cleared on exit in all cases.
  - UNLOCKED:
    - PROG -> PROG, buffer cleared.
    - CLEAR -> LOCKED immediately.
    - UNLOCK_MS expiry -> LOCKED.
    - Digits and ENTER are ignored.
  - PROG:
    - digit -> accept.
    - ENTER with entry_cnt==4 -> code_reg<=entry_buf, clear buffer, go UNLOCKED with a fresh UNLOCK_MS.
    - ENTER with entry_cnt<4 is ignored.
    - CLEAR -> UNLOCKED with buffer cleared and code_reg unchanged.
    - ENTRY_TIMEOUT_MS expiry -> LOCKED with code_reg unchanged.
  - FAIL: all keys ignored; FAIL_MS expiry -> LOCKED.
  - LOCKOUT: all keys ignored; LOCKOUT_MS expiry -> LOCKED, fail_cnt=0.
- Latency: key_valid at cycle t -> entry_buf/entry_cnt update at t+1. ENTER -> CHECK at t+1 -> UNLOCKED/FAIL/LOCKOUT visible at t+2.
- Reset mid-operation returns everything to reset values, including a reprogrammed code_reg, which reverts to DEFAULT_CODE.

Decomposition:
- Package lock_pkg holds:
  - state enum: LOCKED, ENTRY, CHECK, UNLOCKED, PROG, FAIL, LOCKOUT.
  - key constants: KEY_PROG=4'hA, KEY_CLEAR=4'hC, KEY_ENTER=4'hE.
  - helper function is_digit().
- Sub-module ms_timer (params CLK_FREQ, MAX_MS): inputs restart and load_ms; output expire, a 1-cycle pulse. The FSM selects load_ms per state.

Test Plan:
All tests use CLK_FREQ=10_000, UNLOCK_MS=5, ENTRY_TIMEOUT_MS=4, FAIL_MS=2, LOCKOUT_MS=6.
- Correct code: keys 1,2,3,4,E -> entry_buf 16'h1234 and entry_cnt 4 before E; unlocked=1 two cycles after E; unlocked=0 exactly 50 cycles later; fail_cnt=0.
- Wrong code x3 (1,2,3,5,E three times) -> err=1 for 20 cycles after attempts 1 and 2 with fail_cnt 1 then 2; third -> alarm=1 for 60 cycles, fail_cnt=0 after; keys during lockout change nothing.
- Short entry: 1,2,E -> CHECK fails, err=1, fail_cnt=1. Then 5th digit test: 1,2,3,4,9 -> entry_buf stays 16'h1234.
- Reprogram: unlock, A, 9,8,7,6,E -> code_reg=16'h9876, unlocked stays 1. Then C relocks; 9,8,7,6,E unlocks and 1,2,3,4,E fails. Then rst -> 1,2,3,4,E unlocks again.
- Timeouts: key 1, then idle 40 cycles -> entry_cnt=0, state LOCKED, fail_cnt unchanged. Also key_valid on the expiry cycle -> key dropped.
- Ignored keys: B, D, F in every state and E/C/A in LOCKED -> no state, buffer or counter change.
